// File: rtl/pipelined_addsub32.sv
// Pipelined two's-complement adder/subtractor: one SLICE-bit carry slice per stage,
// valid/ready on both sides with a single global stall.
module pipelined_addsub32 #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int unsigned STAGES = WIDTH / SLICE;
   localparam int unsigned SW     = SLICE + 1;

   logic              advance;
   logic [STAGES-1:0] vld_q;
   logic [WIDTH-1:0]  b_eff_c;
   logic [SW-1:0]     slice_c [STAGES];
   logic              ovf_c;

   // Operands not yet consumed, shifted down so the next slice is always bits [SLICE-1:0]
   logic [WIDTH-1:0]  a_q   [STAGES-1];
   logic [WIDTH-1:0]  b_q   [STAGES-1];
   logic [WIDTH-1:0]  sum_q [STAGES-1];
   logic              c_q   [STAGES-1];

   assign advance   = ~out_valid | out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_q[STAGES-1];

   // Per-stage slice adders
   always_comb begin
      b_eff_c    = in_b ^ {WIDTH{in_sub}};
      slice_c[0] = {1'b0, in_a[SLICE-1:0]} + {1'b0, b_eff_c[SLICE-1:0]} + SW'(in_sub);
      for (int k = 1; k < STAGES; k++) begin
         slice_c[k] = {1'b0, a_q[k-1][SLICE-1:0]} + {1'b0, b_q[k-1][SLICE-1:0]}
                    + SW'(c_q[k-1]);
      end
      // Carry into the MSB recovered from the MSB sum bit and its operand bits
      ovf_c = a_q[STAGES-2][SLICE-1] ^ b_q[STAGES-2][SLICE-1]
            ^ slice_c[STAGES-1][SLICE-1] ^ slice_c[STAGES-1][SLICE];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q    <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_ovf  <= 1'b0;
      end else if (advance) begin
         vld_q    <= {vld_q[STAGES-2:0], in_valid};
         a_q[0]   <= in_a >> SLICE;
         b_q[0]   <= b_eff_c >> SLICE;
         sum_q[0] <= WIDTH'(slice_c[0][SLICE-1:0]);
         c_q[0]   <= slice_c[0][SLICE];
         for (int k = 1; k < STAGES - 1; k++) begin
            a_q[k]   <= a_q[k-1] >> SLICE;
            b_q[k]   <= b_q[k-1] >> SLICE;
            sum_q[k] <= sum_q[k-1] | (WIDTH'(slice_c[k][SLICE-1:0]) << (k * SLICE));
            c_q[k]   <= slice_c[k][SLICE];
         end
         out_sum  <= sum_q[STAGES-2]
                   | (WIDTH'(slice_c[STAGES-1][SLICE-1:0]) << ((STAGES - 1) * SLICE));
         out_cout <= slice_c[STAGES-1][SLICE];
         out_ovf  <= ovf_c;
      end
   end

endmodule
